// File: rtl/bus_mem_responder.sv
// bus_mem_responder: fixed-latency ibus/dbus memory responder over one word-addressed RAM
package bus_mem_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;
    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;
    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;
    typedef enum logic {IDLE, BUSY} state_t;
endpackage

module bus_mem_responder
    import bus_mem_pkg::*;
#(
    parameter int unsigned AW        = 16,
    parameter int unsigned LATENCY   = 2,
    parameter bit          STALL_EN  = 1'b0,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp
);
    localparam logic [3:0] LAT = 4'(LATENCY);

    logic [31:0]   r_mem [0:(1<<AW)-1];
    state_t        r_ist, w_ist_nx, r_dst, w_dst_nx;
    logic [3:0]    r_icnt, w_icnt_nx, r_dcnt, w_dcnt_nx;
    logic [AW-1:0] r_iidx, r_didx;
    logic [31:0]   r_idata, r_ddata, r_dwdata, w_iram, w_dram;
    logic [3:0]    r_dstrb;
    logic [7:0]    r_lfsr;
    logic          w_stall, w_ifin, w_dfin, w_iaok, w_daok, w_ihs, w_dhs, w_unused;

    assign w_stall = STALL_EN && r_lfsr[0];
    assign w_ifin  = (r_ist == BUSY) && (r_icnt == 4'd1);
    assign w_dfin  = (r_dst == BUSY) && (r_dcnt == 4'd1);
    assign w_iaok  = ireq.valid && (r_ist == IDLE || w_ifin) && !w_stall;
    assign w_daok  = dreq.valid && (r_dst == IDLE || w_dfin) && !w_stall;
    assign w_ihs   = ireq.valid && w_iaok;
    assign w_dhs   = dreq.valid && w_daok;
    assign w_iram  = r_mem[r_iidx];
    assign w_dram  = r_mem[r_didx];

    // Read data is live in the data_ok cycle, then held until the next completion
    assign iresp = '{addr_ok: w_iaok, data_ok: w_ifin, data: w_ifin ? w_iram : r_idata};
    assign dresp = '{addr_ok: w_daok, data_ok: w_dfin, data: w_dfin ? w_dram : r_ddata};

    assign w_unused = ^{ireq.addr[31:AW+2], ireq.addr[1:0], dreq.addr[31:AW+2], dreq.addr[1:0], dreq.size};

    always_comb begin
        w_ist_nx  = w_ihs ? BUSY : (w_ifin ? IDLE : r_ist);
        w_icnt_nx = w_ihs ? LAT : ((r_ist == BUSY) ? r_icnt - 4'd1 : r_icnt);
        w_dst_nx  = w_dhs ? BUSY : (w_dfin ? IDLE : r_dst);
        w_dcnt_nx = w_dhs ? LAT : ((r_dst == BUSY) ? r_dcnt - 4'd1 : r_dcnt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ist   <= IDLE;
            r_dst   <= IDLE;
            r_icnt  <= '0;
            r_dcnt  <= '0;
            r_idata <= '0;
            r_ddata <= '0;
            r_lfsr  <= LFSR_SEED;
        end else begin
            r_ist  <= w_ist_nx;
            r_dst  <= w_dst_nx;
            r_icnt <= w_icnt_nx;
            r_dcnt <= w_dcnt_nx;
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
            if (w_ifin) r_idata <= w_iram;
            if (w_dfin) r_ddata <= w_dram;
        end
    end

    always_ff @(posedge clk) begin
        if (w_ihs) r_iidx <= ireq.addr[AW+1:2];
        if (w_dhs) begin
            r_didx   <= dreq.addr[AW+1:2];
            r_dstrb  <= dreq.strobe;
            r_dwdata <= dreq.data;
        end
    end

    // Commit on the edge closing the data_ok cycle, so same-cycle readers see the old word
    always_ff @(posedge clk) begin
        if (!reset && w_dfin)
            for (int i = 0; i < 4; i++)
                if (r_dstrb[i]) r_mem[r_didx][8*i +: 8] <= r_dwdata[8*i +: 8];
    end
endmodule
